// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clk_meas waveform analyzer.
// The result struct is sized for the default counter width.
package clk_meas_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        HIGH,
        LOW
    } meas_state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] t_on;
        logic [CNT_W_DEF-1:0] t_off;
        logic [CNT_W_DEF:0]   period;
    } meas_res_t;

    // Edges seen by the FSM lag the input sample by this many cycles beyond one.
    function automatic int sync_latency(input int stages);
        return stages - 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous 1-bit input plus rise/fall detection
// on the synchronized level.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              sig_d_q;
    logic              sig_d_d;
    logic              sig_s;

    assign sig_s = sync_q[STAGES-1];

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], sig_in};
        sig_d_d = sig_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            sig_d_q <= sig_d_d;
        end
    end

    assign rise = sig_s & ~sig_d_q;
    assign fall = ~sig_s & sig_d_q;

endmodule

// File: rtl/clk_meas.sv
// Measures phase, high time, low time and period of an asynchronous periodic
// input in system clock cycles, with stuck detection.
module clk_meas
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] phase_cyc,
    output logic             phase_valid,
    output logic [CNT_W-1:0] t_on_cyc,
    output logic [CNT_W-1:0] t_off_cyc,
    output logic [CNT_W:0]   period_cyc,
    output logic             meas_valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] LAT     = CNT_W'(sync_latency(SYNC_STAGES));
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic rise;
    logic fall;

    meas_state_e      state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [CNT_W-1:0] t_on_hold_q,   t_on_hold_d;
    logic [CNT_W-1:0] phase_cyc_q,   phase_cyc_d;
    logic             phase_valid_q, phase_valid_d;
    logic [CNT_W-1:0] t_on_cyc_q,    t_on_cyc_d;
    logic [CNT_W-1:0] t_off_cyc_q,   t_off_cyc_d;
    logic [CNT_W:0]   period_cyc_q,  period_cyc_d;
    logic             meas_valid_q,  meas_valid_d;
    logic             stuck_q,       stuck_d;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        t_on_hold_d   = t_on_hold_q;
        phase_cyc_d   = phase_cyc_q;
        phase_valid_d = 1'b0;
        t_on_cyc_d    = t_on_cyc_q;
        t_off_cyc_d   = t_off_cyc_q;
        period_cyc_d  = period_cyc_q;
        meas_valid_d  = 1'b0;
        stuck_d       = stuck_q;

        if (start) begin
            state_d = PHASE;
            cnt_d   = '0;
            stuck_d = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                // cnt equals the current edge index here; rises at or before
                // edge 0 are still in the synchronizer and must be skipped.
                PHASE: begin
                    if (rise && (cnt_q > LAT)) begin
                        phase_cyc_d   = cnt_q - LAT;
                        phase_valid_d = 1'b1;
                        state_d       = HIGH;
                        cnt_d         = ONE;
                    end else if (cnt_q == TIMEOUT) begin
                        stuck_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        t_on_hold_d = cnt_q;
                        state_d     = LOW;
                        cnt_d       = ONE;
                    end else if (cnt_q == TIMEOUT) begin
                        stuck_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        t_on_cyc_d   = t_on_hold_q;
                        t_off_cyc_d  = cnt_q;
                        period_cyc_d = {1'b0, t_on_hold_q} + {1'b0, cnt_q};
                        meas_valid_d = 1'b1;
                        state_d      = HIGH;
                        cnt_d        = ONE;
                    end else if (cnt_q == TIMEOUT) begin
                        stuck_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            t_on_hold_q   <= '0;
            phase_cyc_q   <= '0;
            phase_valid_q <= 1'b0;
            t_on_cyc_q    <= '0;
            t_off_cyc_q   <= '0;
            period_cyc_q  <= '0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            t_on_hold_q   <= t_on_hold_d;
            phase_cyc_q   <= phase_cyc_d;
            phase_valid_q <= phase_valid_d;
            t_on_cyc_q    <= t_on_cyc_d;
            t_off_cyc_q   <= t_off_cyc_d;
            period_cyc_q  <= period_cyc_d;
            meas_valid_q  <= meas_valid_d;
            stuck_q       <= stuck_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign phase_cyc   = phase_cyc_q;
    assign phase_valid = phase_valid_q;
    assign t_on_cyc    = t_on_cyc_q;
    assign t_off_cyc   = t_off_cyc_q;
    assign period_cyc  = period_cyc_q;
    assign meas_valid  = meas_valid_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_clk_meas.sv
// Self-checking bench for clk_meas: per-edge sample sequences drive sig_in and a
// run-length model over those samples predicts every valid pulse and value.
`timescale 1ns/1ps
module tb_clk_meas;
    import clk_meas_pkg::*;

    localparam int CW   = CNT_W_DEF;
    localparam int SS   = 3;
    localparam int TO   = 50;
    localparam int MAXE = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sig_in = 1'b0;
    logic          busy;
    logic [CW-1:0] phase_cyc;
    logic          phase_valid;
    logic [CW-1:0] t_on_cyc;
    logic [CW-1:0] t_off_cyc;
    logic [CW:0]   period_cyc;
    logic          meas_valid;
    logic          stuck;

    int n_cmp = 0;
    int n_bad = 0;

    bit        samp      [0:MAXE];
    bit        exp_pv    [0:MAXE];
    int        exp_phase [0:MAXE];
    bit        exp_mv    [0:MAXE];
    meas_res_t exp_res   [0:MAXE];

    int        last_phase = 0;
    meas_res_t last_res   = '0;

    clk_meas #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .sig_in      (sig_in),
        .busy        (busy),
        .phase_cyc   (phase_cyc),
        .phase_valid (phase_valid),
        .t_on_cyc    (t_on_cyc),
        .t_off_cyc   (t_off_cyc),
        .period_cyc  (period_cyc),
        .meas_valid  (meas_valid),
        .stuck       (stuck)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic checkHeld();
        checkOutput("phase_hold", longint'(phase_cyc), longint'(last_phase));
        checkOutput("t_on_hold", longint'(t_on_cyc), longint'(last_res.t_on));
        checkOutput("t_off_hold", longint'(t_off_cyc), longint'(last_res.t_off));
        checkOutput("period_hold", longint'(period_cyc), longint'(last_res.period));
    endtask

    // Phase is the first 0->1 after edge 0; each full rise-fall-rise yields a result.
    task automatic buildExpect(input int len);
        int rises[$];
        int f;
        int e;
        for (int k = 0; k <= len; k++) begin
            exp_pv[k] = 1'b0;
            exp_mv[k] = 1'b0;
        end
        for (int k = 1; k <= len; k++)
            if (samp[k] && !samp[k-1]) rises.push_back(k);
        if (rises.size() > 0 && rises[0] + SS <= len) begin
            exp_pv[rises[0] + SS]    = 1'b1;
            exp_phase[rises[0] + SS] = rises[0];
        end
        for (int i = 0; i + 1 < rises.size(); i++) begin
            f = rises[i] + 1;
            while (samp[f]) f++;
            e = rises[i+1] + SS;
            if (e <= len) begin
                exp_mv[e]         = 1'b1;
                exp_res[e].t_on   = CW'(f - rises[i]);
                exp_res[e].t_off  = CW'(rises[i+1] - f);
                exp_res[e].period = (CW+1)'(rises[i+1] - rises[i]);
            end
        end
    endtask

    task automatic makeWave(input int first_rise, input int on, input int off, input int len,
                            input bit init_hi, input int init_fall);
        for (int k = 0; k <= len; k++) begin
            if (k < first_rise) samp[k] = init_hi && (k < init_fall);
            else                samp[k] = ((k - first_rise) % (on + off)) < on;
        end
    endtask

    task automatic genRandom(output int len);
        bit lvl;
        int k;
        int run;
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(60, 150);
        k   = 0;
        while (k <= len) begin
            run = $urandom_range(1, 20);
            for (int j = 0; j < run && k <= len; j++) begin
                samp[k] = lvl;
                k++;
            end
            lvl = !lvl;
        end
    endtask

    task automatic applyStimulus(input int len, input bit with_stop);
        buildExpect(len);
        @(negedge clk);
        start  = 1'b1;
        stop   = with_stop;
        sig_in = samp[0];
        @(posedge clk);
        #1;
        checkOutput("busy_at_start", longint'(busy), 1);
        checkOutput("stuck_at_start", longint'(stuck), 0);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start  = 1'b0;
            stop   = 1'b0;
            sig_in = samp[k];
            @(posedge clk);
            #1;
            checkOutput("busy", longint'(busy), 1);
            checkOutput("phase_valid", longint'(phase_valid), longint'(exp_pv[k]));
            checkOutput("meas_valid", longint'(meas_valid), longint'(exp_mv[k]));
            if (exp_pv[k]) last_phase = exp_phase[k];
            if (exp_mv[k]) last_res = exp_res[k];
            checkHeld();
        end
    endtask

    task automatic stopRun();
        @(negedge clk);
        stop   = 1'b1;
        sig_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        checkOutput("busy_after_stop", longint'(busy), 0);
        checkOutput("meas_valid_at_stop", longint'(meas_valid), 0);
        checkOutput("phase_valid_at_stop", longint'(phase_valid), 0);
        checkHeld();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stop   = 1'b0;
            sig_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("busy_idle", longint'(busy), 0);
            checkOutput("meas_valid_idle", longint'(meas_valid), 0);
            checkOutput("phase_valid_idle", longint'(phase_valid), 0);
            checkHeld();
        end
    endtask

    task automatic timeoutRun();
        @(negedge clk);
        start  = 1'b1;
        stop   = 1'b0;
        sig_in = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= TO + 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("to_phase_valid", longint'(phase_valid), 0);
            checkOutput("to_meas_valid", longint'(meas_valid), 0);
            if (k == TO - 10) begin
                checkOutput("to_busy_early", longint'(busy), 1);
                checkOutput("to_stuck_early", longint'(stuck), 0);
            end
        end
        checkOutput("to_stuck", longint'(stuck), 1);
        checkOutput("to_busy", longint'(busy), 0);
        checkHeld();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, longint'(busy), 0);
        checkOutput({tag, "_stuck"}, longint'(stuck), 0);
        checkOutput({tag, "_phase_valid"}, longint'(phase_valid), 0);
        checkOutput({tag, "_meas_valid"}, longint'(meas_valid), 0);
        checkOutput({tag, "_phase"}, longint'(phase_cyc), 0);
        checkOutput({tag, "_t_on"}, longint'(t_on_cyc), 0);
        checkOutput({tag, "_t_off"}, longint'(t_off_cyc), 0);
        checkOutput({tag, "_period"}, longint'(period_cyc), 0);
    endtask

    initial begin
        int len;
        bit ws;

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Symmetric wave, then stop while HIGH; results must hold.
        makeWave(7, 5, 5, 60, 1'b0, 0);
        applyStimulus(60, 1'b0);
        stopRun();

        // Asymmetric wave started with start and stop together.
        makeWave(1, 3, 12, 70, 1'b0, 0);
        applyStimulus(70, 1'b1);

        // Level high at start is ignored; restart while busy.
        makeWave(9, 4, 6, 40, 1'b1, 4);
        applyStimulus(40, 1'b0);
        stopRun();

        timeoutRun();

        for (int r = 0; r < 12; r++) begin
            genRandom(len);
            ws = 1'($urandom_range(0, 1));
            applyStimulus(len, ws);
            if ($urandom_range(0, 1) == 1) stopRun();
        end

        // Reset asserted while the FSM is in LOW.
        makeWave(7, 5, 5, 17, 1'b0, 0);
        applyStimulus(17, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        last_phase = 0;
        last_res   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
            @(posedge clk);
            #1;
            checkOutput("post_reset_busy", longint'(busy), 0);
            checkOutput("post_reset_meas_valid", longint'(meas_valid), 0);
            checkOutput("post_reset_phase_valid", longint'(phase_valid), 0);
            checkHeld();
        end

        genRandom(len);
        applyStimulus(len, 1'b0);
        stopRun();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
